// File: rtl/id_ex_hazard_ctrl.sv
// id_ex_hazard_ctrl: tracks EX/MEM/WB destinations and returns stall/bubble to decode and EX operand forwarding selects.
// Build option HAZARD_FWD_EN: defined = forwarding + 1-cycle load-use stall; undefined = no forwarding, stall on any RAW in EX or MEM.
module id_ex_hazard_ctrl #(
  parameter int AW     = 3,
  parameter int SCNT_W = 8
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [AW-1:0]     id_ra,
  input  logic [AW-1:0]     id_rb,
  input  logic [AW-1:0]     id_rd,
  input  logic              id_uses_rb,
  input  logic              id_regdst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_flush,
  output logic              stall,
  output logic              bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [SCNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic          v;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [AW-1:0] dest;
    logic          rw;
    logic          mr;
  } slot_t;

  localparam logic [AW-1:0]     REG_ZERO  = {AW{1'b0}};
  localparam logic [SCNT_W-1:0] CNT_MAX   = {SCNT_W{1'b1}};
  localparam logic [SCNT_W-1:0] CNT_ONE   = {{(SCNT_W-1){1'b0}}, 1'b1};
  localparam slot_t             SLOT_NONE = {(3*AW+3){1'b0}};

  slot_t ex_r;
  slot_t mem_r;
  slot_t wb_r;
  slot_t id_slot_s;
  logic  raw_stall_s;
  logic  load_ex_s;
  logic  unused_s;

  // R0 is hardwired zero, so a slot only produces a value when it writes a non-zero register.
  function automatic logic slot_hit(input slot_t s, input logic [AW-1:0] src);
    return s.v & s.rw & (s.dest != REG_ZERO) & (s.dest == src);
  endfunction

  // Decode instruction packed into slot form, destination resolved through RegDst.
  always_comb begin
    id_slot_s      = SLOT_NONE;
    id_slot_s.v    = 1'b1;
    id_slot_s.ra   = id_ra;
    id_slot_s.rb   = id_rb;
    id_slot_s.dest = id_regdst ? id_rd : id_rb;
    id_slot_s.rw   = id_regwrite;
    id_slot_s.mr   = id_memread;
  end

  // Hazard detection, forwarding selects, and the flush override.
  always_comb begin
    raw_stall_s = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
`ifdef HAZARD_FWD_EN
    raw_stall_s = id_valid & ex_r.mr &
                  (slot_hit(ex_r, id_ra) | (id_uses_rb & slot_hit(ex_r, id_rb)));
    // MEM holds the newer value, so it outranks WB.
    if (slot_hit(mem_r, ex_r.ra)) begin
      fwd_a = 2'b01;
    end else if (slot_hit(wb_r, ex_r.ra)) begin
      fwd_a = 2'b10;
    end else begin
      fwd_a = 2'b00;
    end
    if (slot_hit(mem_r, ex_r.rb)) begin
      fwd_b = 2'b01;
    end else if (slot_hit(wb_r, ex_r.rb)) begin
      fwd_b = 2'b10;
    end else begin
      fwd_b = 2'b00;
    end
`else
    raw_stall_s = id_valid &
                  (slot_hit(ex_r, id_ra)  | (id_uses_rb & slot_hit(ex_r, id_rb)) |
                   slot_hit(mem_r, id_ra) | (id_uses_rb & slot_hit(mem_r, id_rb)));
`endif
    stall  = raw_stall_s & ~id_flush;
    bubble = raw_stall_s | id_flush;
  end

  assign load_ex_s = id_valid & ~id_flush & ~stall;
  assign unused_s  = ^{ex_r.mr, mem_r, wb_r};

  // Slot shift register and saturating stall counter.
  always_ff @(posedge clk1) begin
    if (rst) begin
      ex_r      <= SLOT_NONE;
      mem_r     <= SLOT_NONE;
      wb_r      <= SLOT_NONE;
      stall_cnt <= {SCNT_W{1'b0}};
    end else begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      if (load_ex_s) begin
        ex_r <= id_slot_s;
      end else begin
        ex_r <= SLOT_NONE;
      end
      if (stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end else begin
        stall_cnt <= stall_cnt;
      end
    end
  end

endmodule
